// File: rtl/ps2_key_event_decoder.sv
// PS/2 scan-code byte stream to key events, with prefix FSM, modifier
// tracking, optional repeat suppression and a show-ahead event FIFO.
module ps2_key_event_decoder #(
  parameter int FIFO_DEPTH      = 8,
  parameter int CNT_W           = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_pop,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [3:0]       ev_mods,
  output logic             key_down,
  output logic [CNT_W-1:0] press_count,
  output logic             overflow
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam bit SUP = (SUPPRESS_REPEAT != 0);

  typedef enum logic [2:0] {
    IDLE, EXT, BRK, EXT_BRK, SKIP
  } state_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
  } ev_t;

  state_t     state, state_d;
  logic [2:0] skip_cnt, skip_d;
  logic       cool;

  logic is_e0, is_f0, is_e1, is_junk;
  logic ev_fire, ev_x, ev_b;

  // ready from ps2_keyboard lags our pop by a cycle
  assign rx_pop = rx_valid & ~cool;

  always_ff @(posedge clk) begin
    if (rst) cool <= 1'b0;
    else     cool <= rx_pop;
  end

  assign is_e0   = (rx_data == 8'hE0);
  assign is_f0   = (rx_data == 8'hF0);
  assign is_e1   = (rx_data == 8'hE1);
  assign is_junk = rx_data inside {8'hAA, 8'hFA, 8'hEE,
                                   8'hFE, 8'h00, 8'hFF};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_d;
      skip_cnt <= skip_d;
    end
  end

  always_comb begin
    state_d = state;
    skip_d  = skip_cnt;
    if (rx_pop) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            is_e0: state_d = EXT;
            is_f0: state_d = BRK;
            is_e1: begin
              state_d = SKIP;
              skip_d  = 3'd7;
            end
            default: state_d = IDLE;
          endcase
        end
        EXT:     state_d = is_f0 ? EXT_BRK : IDLE;
        BRK:     state_d = IDLE;
        EXT_BRK: state_d = IDLE;
        SKIP: begin
          skip_d = skip_cnt - 3'd1;
          if (skip_cnt <= 3'd1) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ev_fire = 1'b0;
    ev_x    = 1'b0;
    ev_b    = 1'b0;
    if (rx_pop) begin
      unique case (state)
        IDLE: ev_fire = ~(is_e0 | is_f0 | is_e1 | is_junk);
        EXT: begin
          ev_fire = ~is_f0;
          ev_x    = 1'b1;
        end
        BRK: begin
          ev_fire = 1'b1;
          ev_b    = 1'b1;
        end
        EXT_BRK: begin
          ev_fire = 1'b1;
          ev_x    = 1'b1;
          ev_b    = 1'b1;
        end
        default: ev_fire = 1'b0;
      endcase
    end
  end

  logic [8:0] held;
  logic       same_key, accept;

  assign same_key = key_down & ({ev_x, rx_data} == held);
  assign accept   = ev_fire & ~(SUP & ~ev_b & same_key);

  logic shl, shr, ctrl, alt, caps;
  logic shl_d, shr_d, ctrl_d, alt_d, caps_d;
  logic [3:0] mods_d;

  always_comb begin
    shl_d  = shl;
    shr_d  = shr;
    ctrl_d = ctrl;
    alt_d  = alt;
    caps_d = caps;
    if (accept) begin
      if (!ev_x && rx_data == 8'h12) shl_d = ~ev_b;
      if (!ev_x && rx_data == 8'h59) shr_d = ~ev_b;
      if (rx_data == 8'h14)          ctrl_d = ~ev_b;
      if (rx_data == 8'h11)          alt_d = ~ev_b;
      if (!ev_x && !ev_b && rx_data == 8'h58)
        caps_d = ~caps;
    end
  end

  assign mods_d = {caps_d, alt_d, ctrl_d, shl_d | shr_d};

  always_ff @(posedge clk) begin
    if (rst) begin
      shl         <= 1'b0;
      shr         <= 1'b0;
      ctrl        <= 1'b0;
      alt         <= 1'b0;
      caps        <= 1'b0;
      held        <= 9'd0;
      key_down    <= 1'b0;
      press_count <= '0;
    end else begin
      shl  <= shl_d;
      shr  <= shr_d;
      ctrl <= ctrl_d;
      alt  <= alt_d;
      caps <= caps_d;
      if (accept && !ev_b) begin
        held     <= {ev_x, rx_data};
        key_down <= 1'b1;
      end else if (accept && same_key) begin
        key_down <= 1'b0;
      end
      if (ev_fire && ev_b) press_count <= press_count + 1'b1;
    end
  end

  ev_t         mem [FIFO_DEPTH];
  ev_t         head, last;
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, wr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = ~empty & ev_ready;
  assign wr    = accept & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= {rx_data, ev_x, ev_b, mods_d};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      last     <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (accept && full && !pop) overflow <= 1'b1;
      if (!empty) last <= head;
    end
  end

  // empty FIFO keeps presenting the last head it showed
  assign head     = mem[rd_ptr[AW-1:0]];
  assign ev_valid = ~empty;
  assign ev_code  = empty ? last.code : head.code;
  assign ev_ext   = empty ? last.ext  : head.ext;
  assign ev_break = empty ? last.brk  : head.brk;
  assign ev_mods  = empty ? last.mods : head.mods;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed bench for ps2_key_event_decoder: three instances (default,
// no repeat suppression, 4-deep FIFO) fed the same byte stream.
module tb_ps2_key_event_decoder;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] mods;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       m_ready = 1'b1;
  logic       n_ready = 1'b1;
  logic       f_ready = 1'b1;

  logic       m_rx_pop, m_ev_valid, m_ev_ext, m_ev_break;
  logic       m_key_down, m_overflow;
  logic [7:0] m_ev_code, m_press_count;
  logic [3:0] m_ev_mods;
  logic       n_rx_pop, n_ev_valid, n_ev_ext, n_ev_break;
  logic       n_key_down, n_overflow;
  logic [7:0] n_ev_code, n_press_count;
  logic [3:0] n_ev_mods;
  logic       f_rx_pop, f_ev_valid, f_ev_ext, f_ev_break;
  logic       f_key_down, f_overflow;
  logic [7:0] f_ev_code, f_press_count;
  logic [3:0] f_ev_mods;

  int checks = 0;
  int failures = 0;
  int exp_press = 0;
  ev_t q_m[$];
  ev_t q_n[$];
  ev_t q_f[$];
  logic prev_pop = 1'b0;

  always #5 clk = ~clk;

  ps2_key_event_decoder dut_m (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_pop(m_rx_pop), .ev_valid(m_ev_valid), .ev_ready(m_ready),
    .ev_code(m_ev_code), .ev_ext(m_ev_ext), .ev_break(m_ev_break),
    .ev_mods(m_ev_mods), .key_down(m_key_down),
    .press_count(m_press_count), .overflow(m_overflow));

  ps2_key_event_decoder #(.SUPPRESS_REPEAT(0)) dut_n (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_pop(n_rx_pop), .ev_valid(n_ev_valid), .ev_ready(n_ready),
    .ev_code(n_ev_code), .ev_ext(n_ev_ext), .ev_break(n_ev_break),
    .ev_mods(n_ev_mods), .key_down(n_key_down),
    .press_count(n_press_count), .overflow(n_overflow));

  ps2_key_event_decoder #(.FIFO_DEPTH(4)) dut_f (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_pop(f_rx_pop), .ev_valid(f_ev_valid), .ev_ready(f_ready),
    .ev_code(f_ev_code), .ev_ext(f_ev_ext), .ev_break(f_ev_break),
    .ev_mods(f_ev_mods), .key_down(f_key_down),
    .press_count(f_press_count), .overflow(f_overflow));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : mon_pop
    if (m_rx_pop | n_rx_pop | f_rx_pop) begin
      chk("pop_spacing", {31'd0, prev_pop}, 32'd0);
      chk("pop_agree", {30'd0, n_rx_pop, f_rx_pop},
          {30'd0, m_rx_pop, m_rx_pop});
    end
    prev_pop = m_rx_pop;
  end

  always @(negedge clk) begin : sb_m
    ev_t e;
    if (!rst && m_ev_valid && m_ready) begin
      e = 'x;
      if (q_m.size() != 0) e = q_m.pop_front();
      chk("main_ev", {18'd0, m_ev_code, m_ev_ext, m_ev_break, m_ev_mods},
          {18'd0, e});
    end
  end

  always @(negedge clk) begin : sb_n
    ev_t e;
    if (!rst && n_ev_valid && n_ready) begin
      e = 'x;
      if (q_n.size() != 0) e = q_n.pop_front();
      chk("norep_ev", {18'd0, n_ev_code, n_ev_ext, n_ev_break, n_ev_mods},
          {18'd0, e});
    end
  end

  always @(negedge clk) begin : sb_f
    ev_t e;
    if (!rst && f_ev_valid && f_ready) begin
      e = 'x;
      if (q_f.size() != 0) e = q_f.pop_front();
      chk("fifo4_ev", {18'd0, f_ev_code, f_ev_ext, f_ev_break, f_ev_mods},
          {18'd0, e});
    end
  end

  task automatic ex(input logic [7:0] c, input logic x, input logic b,
                    input logic [3:0] md);
    ev_t e;
    e = {c, x, b, md};
    q_m.push_back(e);
    q_n.push_back(e);
    q_f.push_back(e);
    if (b) exp_press++;
  endtask

  task automatic send(input logic [7:0] b);
    bit got;
    got = 1'b0;
    rx_valid = 1'b1;
    rx_data = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_rx_pop) begin
        got = 1'b1;
        break;
      end
    end
    chk("send_pop", {31'd0, got}, 32'd1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q_m.size() == 0 && q_n.size() == 0 && !m_ev_valid &&
          !n_ev_valid && (!f_ready || (q_f.size() == 0 && !f_ev_valid))) begin
        done = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk(tag, {31'd0, done}, 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_press = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", {31'd0, m_ev_valid}, 32'd0);
    chk("rst_pop", {31'd0, m_rx_pop}, 32'd0);
    chk("rst_outs", {18'd0, m_ev_code, m_ev_ext, m_ev_break, m_ev_mods},
        32'd0);
    chk("rst_misc", {22'd0, m_key_down, m_press_count, m_overflow}, 32'd0);

    ex(8'h1C, 0, 0, 4'h0);
    send(8'h1C);
    chk("kd_make", {31'd0, m_key_down}, 32'd1);
    ex(8'h1C, 0, 1, 4'h0);
    send(8'hF0);
    send(8'h1C);
    chk("kd_break", {31'd0, m_key_down}, 32'd0);
    chk("press_1", {24'd0, m_press_count}, 32'd1);
    drain("drain_basic");

    ex(8'h75, 1, 0, 4'h0);
    send(8'hE0);
    send(8'h75);
    ex(8'h75, 1, 1, 4'h0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    drain("drain_ext");

    ex(8'h1C, 0, 0, 4'h0);
    q_n.push_back({8'h1C, 1'b0, 1'b0, 4'h0});
    q_n.push_back({8'h1C, 1'b0, 1'b0, 4'h0});
    ex(8'h1C, 0, 1, 4'h0);
    send(8'h1C);
    send(8'h1C);
    send(8'h1C);
    send(8'hF0);
    send(8'h1C);
    drain("drain_repeat");

    ex(8'h12, 0, 0, 4'h1); send(8'h12);
    ex(8'h1C, 0, 0, 4'h1); send(8'h1C);
    ex(8'h1C, 0, 1, 4'h1); send(8'hF0); send(8'h1C);
    ex(8'h12, 0, 1, 4'h0); send(8'hF0); send(8'h12);
    ex(8'h58, 0, 0, 4'h8); send(8'h58);
    ex(8'h58, 0, 1, 4'h8); send(8'hF0); send(8'h58);
    ex(8'h58, 0, 0, 4'h0); send(8'h58);
    ex(8'h58, 0, 1, 4'h0); send(8'hF0); send(8'h58);
    ex(8'h14, 1, 0, 4'h2); send(8'hE0); send(8'h14);
    ex(8'h14, 1, 1, 4'h0); send(8'hE0); send(8'hF0); send(8'h14);
    ex(8'h11, 0, 0, 4'h4); send(8'h11);
    ex(8'h11, 0, 1, 4'h0); send(8'hF0); send(8'h11);
    ex(8'h59, 0, 0, 4'h1); send(8'h59);
    ex(8'h12, 0, 0, 4'h1); send(8'h12);
    ex(8'h59, 0, 1, 4'h1); send(8'hF0); send(8'h59);
    ex(8'h12, 0, 1, 4'h0); send(8'hF0); send(8'h12);
    drain("drain_mods");

    send(8'hAA);
    send(8'hFA);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    ex(8'h1C, 0, 0, 4'h0); send(8'h1C);
    ex(8'h1C, 0, 1, 4'h0); send(8'hF0); send(8'h1C);
    drain("drain_skip");
    chk("press_pre_rst", {24'd0, m_press_count}, exp_press);

    send(8'hE0);
    send(8'hF0);
    do_reset();
    chk("midrst_press", {24'd0, m_press_count}, 32'd0);
    chk("midrst_kd", {31'd0, m_key_down}, 32'd0);
    ex(8'h1C, 0, 0, 4'h0);
    send(8'h1C);
    chk("midrst_kd2", {31'd0, m_key_down}, 32'd1);
    drain("drain_rst");

    f_ready = 1'b0;
    ex(8'h15, 0, 0, 4'h0);
    ex(8'h16, 0, 0, 4'h0);
    ex(8'h1C, 0, 0, 4'h0);
    ex(8'h1D, 0, 0, 4'h0);
    q_m.push_back({8'h1E, 1'b0, 1'b0, 4'h0});
    q_n.push_back({8'h1E, 1'b0, 1'b0, 4'h0});
    send(8'h15); send(8'h16); send(8'h1C); send(8'h1D);
    chk("f_no_ovf_yet", {31'd0, f_overflow}, 32'd0);
    send(8'h1E);
    chk("f_overflow", {31'd0, f_overflow}, 32'd1);
    chk("m_no_overflow", {30'd0, m_overflow, n_overflow}, 32'd0);
    chk("f_head", {23'd0, f_ev_valid, f_ev_code}, {23'd1, 8'h15});
    drain("drain_mn");
    f_ready = 1'b1;
    drain("drain_f");
    chk("f_empty", {31'd0, f_ev_valid}, 32'd0);
    chk("f_hold", {18'd0, f_ev_code, f_ev_ext, f_ev_break, f_ev_mods},
        {18'd0, 8'h1D, 6'd0});
    chk("f_ovf_sticky", {31'd0, f_overflow}, 32'd1);
    chk("kd_all", {29'd0, m_key_down, n_key_down, f_key_down}, 32'd7);
    chk("press_all", {8'd0, m_press_count, n_press_count, f_press_count},
        {8'd0, exp_press[7:0], exp_press[7:0], exp_press[7:0]});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
